// File: rtl/load_store_ctrl_pkg.sv
// Shared types and constants for the load/store controller.
// Holds the FSM state enum, funct3 width codes, exception causes and decode helpers.
package load_store_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_LOAD_MISALIGNED  = 2'b00;
  localparam logic [1:0] EXC_STORE_MISALIGNED = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL_WIDTH    = 2'b10;

  // Unsigned widths only exist for loads; stores accept B/H/W.
  function automatic logic f3_legal(input logic is_load, input logic [2:0] funct3);
    if (is_load)
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
             (funct3 == F3_BU) || (funct3 == F3_HU);
    else
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_ctrl_if.sv
// Data-memory request/response bus between the load/store controller and memory.
interface load_store_ctrl_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_load_align.sv
// Load return alignment: picks the addressed byte/half lane and sign- or zero-extends it.
module lsu_load_align
  import load_store_ctrl_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// Load/store unit controller: issues one aligned data-memory access per EX memory op,
// stalls the pipeline until completion, and flags misaligned or illegal-width ops.
//
// state    | meaning
// IDLE     | no access in flight; decode EX op, accept or raise exception
// REQ      | dmem_req high with latched addr/be/wdata/we until gnt
// WAIT_RSP | load granted; waiting for rvalid to write back
module load_store_ctrl
  import load_store_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid_i,
  input  logic                      ex_is_load_i,
  input  logic                      ex_is_store_i,
  input  logic [2:0]                ex_funct3_i,
  input  logic [31:0]               ex_addr_i,
  input  logic [31:0]               ex_wdata_i,
  input  logic [4:0]                ex_rd_i,
  load_store_ctrl_if.master         dmem,
  output logic                      ldst_stall_o,
  output logic                      wb_valid_o,
  output logic [4:0]                wb_rd_o,
  output logic [31:0]               wb_data_o,
  output logic                      exc_valid_o,
  output logic [1:0]                exc_cause_o
);

  lsu_state_t  state_q, state_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic        exc_valid_q;
  logic [1:0]  exc_cause_q;

  logic        op_load, op_store, op_valid, op_illegal, op_misal;
  logic        accept, exc_d, stall, wb_valid;
  logic [1:0]  exc_cause_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_data;

  // A simultaneous load+store flag resolves to a load.
  assign op_load    = ex_is_load_i;
  assign op_store   = ex_is_store_i & ~ex_is_load_i;
  assign op_valid   = ex_valid_i & (op_load | op_store);
  assign op_illegal = ~f3_legal(op_load, ex_funct3_i);
  assign op_misal   = addr_misaligned(ex_funct3_i, ex_addr_i[1:0]);

  always_comb begin
    case (ex_funct3_i[1:0])
      2'b00: begin
        be_d    = 4'b0001 << ex_addr_i[1:0];
        wdata_d = {4{ex_wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = ex_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{ex_wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = ex_wdata_i;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    accept      = 1'b0;
    wb_valid    = 1'b0;
    exc_d       = 1'b0;
    exc_cause_d = EXC_ILLEGAL_WIDTH;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (op_illegal || op_misal) begin
            exc_d       = 1'b1;
            exc_cause_d = op_illegal ? EXC_ILLEGAL_WIDTH :
                          (op_load ? EXC_LOAD_MISALIGNED : EXC_STORE_MISALIGNED);
          end else begin
            accept  = 1'b1;
            stall   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem.gnt) begin
          if (we_q) begin
            stall   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        stall = 1'b1;
        if (dmem.rvalid) begin
          stall    = 1'b0;
          wb_valid = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      funct3_q    <= '0;
      offset_q    <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
    end else begin
      exc_valid_q <= exc_d;
      if (exc_d) exc_cause_q <= exc_cause_d;
      if (accept) begin
        we_q     <= op_store;
        addr_q   <= {ex_addr_i[31:2], 2'b00};
        be_q     <= be_d;
        wdata_q  <= wdata_d;
        rd_q     <= ex_rd_i;
        funct3_q <= ex_funct3_i;
        offset_q <= ex_addr_i[1:0];
      end
    end
  end

  lsu_load_align u_load_align (
    .rdata_i  (dmem.rdata),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  assign dmem.req     = (state_q == REQ);
  assign dmem.we      = we_q;
  assign dmem.addr    = addr_q;
  assign dmem.be      = be_q;
  assign dmem.wdata   = wdata_q;

  assign ldst_stall_o = stall;
  assign wb_valid_o   = wb_valid;
  assign wb_rd_o      = wb_valid ? rd_q : 5'd0;
  assign wb_data_o    = wb_valid ? load_data : 32'd0;
  assign exc_valid_o  = exc_valid_q;
  assign exc_cause_o  = exc_cause_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Self-checking bench for load_store_ctrl: directed scenarios plus randomized ops
// compared against a behavioural model of access width, lanes, latency and exceptions.
module tb_load_store_ctrl;
  import load_store_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        ldst_stall, wb_valid, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  exc_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_ctrl_if dmem_if ();

  load_store_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid_i    (ex_valid),
    .ex_is_load_i  (ex_is_load),
    .ex_is_store_i (ex_is_store),
    .ex_funct3_i   (ex_funct3),
    .ex_addr_i     (ex_addr),
    .ex_wdata_i    (ex_wdata),
    .ex_rd_i       (ex_rd),
    .dmem          (dmem_if),
    .ldst_stall_o  (ldst_stall),
    .wb_valid_o    (wb_valid),
    .wb_rd_o       (wb_rd),
    .wb_data_o     (wb_data),
    .exc_valid_o   (exc_valid),
    .exc_cause_o   (exc_cause)
  );

  typedef struct {
    int          stall_cycles;
    int          req_cycles;
    int          hold_cycles;
    int          wb_count;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    int          exc_count;
    int          exc_cycle;
    logic [1:0]  exc_cause;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    bit          unstable;
    bit          timeout;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what one EX op should produce, from width/alignment rules.
  function automatic obs_t model(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [4:0] rd, input int gw, input int rw,
                                 input logic [31:0] rdata);
    obs_t e;
    bit is_ld, is_st, legal;
    int size, off;
    logic [31:0] v, mask;
    e = '{default: 0};
    e.hold_cycles = 1;
    is_ld = ld;
    is_st = st && !ld;
    if (!is_ld && !is_st) return e;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(addr % 4);
    legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal || (addr % size) != 0) begin
      e.exc_count = 1;
      e.exc_cycle = 1;
      e.exc_cause = !legal ? 2'd2 : (is_ld ? 2'd0 : 2'd1);
      return e;
    end
    e.req_cycles = gw + 1;
    e.addr = addr - (addr % 4);
    e.we = is_st;
    if (is_st) begin
      e.be = 4'(((1 << size) - 1) << off);
      e.wdata = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
      e.stall_cycles = 1 + gw;
    end else begin
      v = rdata >> (8 * off);
      mask = (size == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * size)) - 1);
      v = v & mask;
      if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~mask;
      e.wb_data = v;
      e.wb_rd = rd;
      e.wb_count = 1;
      e.stall_cycles = 2 + gw + rw;
    end
    e.hold_cycles = e.stall_cycles + 1;
    return e;
  endfunction

  // Drives one EX op with a memory responder (gw wait cycles before gnt, rw before rvalid)
  // and records what the DUT did. Starts and ends just after a rising edge.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input int gw, input int rw,
                        input logic [31:0] rdata, output obs_t o);
    int req_seen, rsp_seen, k;
    bit pending, done;
    o = '{default: 0};
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    dmem_if.rdata = rdata;
    req_seen = 0; rsp_seen = 0; pending = 1'b0; done = 1'b0; k = 0;
    while (!done && k < 60) begin
      dmem_if.gnt    = dmem_if.req && (req_seen == gw);
      dmem_if.rvalid = pending && (rsp_seen == rw);
      #1;
      if (ldst_stall) o.stall_cycles++;
      if (dmem_if.req) begin
        if (o.req_cycles == 0) begin
          o.addr = dmem_if.addr; o.be = dmem_if.be; o.wdata = dmem_if.wdata; o.we = dmem_if.we;
        end else if (o.addr !== dmem_if.addr || o.be !== dmem_if.be ||
                     o.wdata !== dmem_if.wdata || o.we !== dmem_if.we) begin
          o.unstable = 1'b1;
        end
        o.req_cycles++;
      end
      if (wb_valid) begin o.wb_count++; o.wb_data = wb_data; o.wb_rd = wb_rd; end
      if (exc_valid) begin o.exc_count++; o.exc_cycle = k; o.exc_cause = exc_cause; end
      if (!ldst_stall) done = 1'b1;
      if (pending) begin
        if (dmem_if.rvalid) pending = 1'b0;
        else rsp_seen++;
      end
      if (dmem_if.req) begin
        if (dmem_if.gnt && !dmem_if.we) pending = 1'b1;
        req_seen++;
      end
      k++;
      o.hold_cycles = k;
      tick();
    end
    if (!done) o.timeout = 1'b1;
    ex_valid = 1'b0; dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
    repeat (2) begin
      #1;
      if (ldst_stall) o.stall_cycles++;
      if (dmem_if.req) o.req_cycles++;
      if (wb_valid) o.wb_count++;
      if (exc_valid) begin o.exc_count++; o.exc_cycle = k; o.exc_cause = exc_cause; end
      k++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0; dmem_if.rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({dmem_if.req, dmem_if.we, dmem_if.addr, dmem_if.be, dmem_if.wdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus got req=%b we=%b addr=%h be=%b wdata=%h want all 0",
               dmem_if.req, dmem_if.we, dmem_if.addr, dmem_if.be, dmem_if.wdata);
    end
    checks++;
    if ({ldst_stall, wb_valid, exc_valid, exc_cause} !== '0) begin
      errors++;
      $display("FAIL reset_outs got stall=%b wb=%b exc=%b cause=%b want 0",
               ldst_stall, wb_valid, exc_valid, exc_cause);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_word();
    obs_t o;
    run_op(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0, o);
    checks++;
    if (o.addr !== 32'h100 || o.be !== 4'b1111 || o.we !== 1'b1 || o.wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_bus got addr=%h be=%b we=%b wdata=%h want 00000100 1111 1 deadbeef",
               o.addr, o.be, o.we, o.wdata);
    end
    checks++;
    if (o.stall_cycles != 1 || o.hold_cycles != 2 || o.timeout) begin
      errors++;
      $display("FAIL sw_latency got stall=%0d hold=%0d want 1 2", o.stall_cycles, o.hold_cycles);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL sw_idle got state=%0d want IDLE", dut.state_q);
    end
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_op(1'b1, 1'b0, F3_B, 32'h203, 32'h0, 5'd7, 0, 0, 32'h80A5_5A01, o);
    checks++;
    if (o.wb_data !== 32'hFFFF_FF80 || o.wb_count != 1 || o.wb_rd !== 5'd7) begin
      errors++;
      $display("FAIL lb got data=%h n=%0d rd=%0d want ffffff80 1 7", o.wb_data, o.wb_count, o.wb_rd);
    end
    checks++;
    if (o.stall_cycles != 2 || o.hold_cycles != 3 || o.addr !== 32'h200 || o.we !== 1'b0) begin
      errors++;
      $display("FAIL lb_latency got stall=%0d hold=%0d addr=%h we=%b want 2 3 00000200 0",
               o.stall_cycles, o.hold_cycles, o.addr, o.we);
    end
    run_op(1'b1, 1'b0, F3_BU, 32'h203, 32'h0, 5'd9, 0, 0, 32'h80A5_5A01, o);
    checks++;
    if (o.wb_data !== 32'h0000_0080 || o.wb_count != 1) begin
      errors++;
      $display("FAIL lbu got data=%h n=%0d want 00000080 1", o.wb_data, o.wb_count);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_op(1'b1, 1'b0, F3_H, 32'h201, 32'h0, 5'd3, 0, 0, 32'h0, o);
    checks++;
    if (o.exc_count != 1 || o.exc_cycle != 1 || o.exc_cause !== EXC_LOAD_MISALIGNED) begin
      errors++;
      $display("FAIL lh_misal got n=%0d cyc=%0d cause=%b want 1 1 00", o.exc_count, o.exc_cycle, o.exc_cause);
    end
    checks++;
    if (o.req_cycles != 0 || o.stall_cycles != 0 || o.wb_count != 0) begin
      errors++;
      $display("FAIL lh_misal_quiet got req=%0d stall=%0d wb=%0d want 0 0 0",
               o.req_cycles, o.stall_cycles, o.wb_count);
    end
  endtask

  task automatic test_store_half_wait();
    obs_t o;
    run_op(1'b0, 1'b1, F3_H, 32'h42, 32'h0000_1234, 5'd0, 3, 0, 32'h0, o);
    checks++;
    if (o.wdata !== 32'h1234_1234 || o.be !== 4'b1100 || o.addr !== 32'h40 || o.unstable) begin
      errors++;
      $display("FAIL sh_bus got wdata=%h be=%b addr=%h unstable=%b want 12341234 1100 00000040 0",
               o.wdata, o.be, o.addr, o.unstable);
    end
    checks++;
    if (o.stall_cycles != 4 || o.req_cycles != 4) begin
      errors++;
      $display("FAIL sh_stall got stall=%0d req=%0d want 4 4", o.stall_cycles, o.req_cycles);
    end
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0;
    ex_funct3 = F3_W; ex_addr = 32'h300; ex_rd = 5'd5;
    dmem_if.rdata = 32'hCAFE_F00D;
    tick();
    dmem_if.gnt = 1'b1;
    tick();
    dmem_if.gnt = 1'b0;
    ex_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dmem_if.req, dmem_if.we, dmem_if.addr, dmem_if.be, ldst_stall, wb_valid, exc_valid} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outs got req=%b addr=%h be=%b stall=%b wb=%b want all 0",
               dmem_if.req, dmem_if.addr, dmem_if.be, ldst_stall, wb_valid);
    end
    #1 rst_n = 1'b1;
    tick();
    dmem_if.rvalid = 1'b1;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || ldst_stall !== 1'b0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL rst_mid_rsp got wb=%b stall=%b state=%0d want 0 0 IDLE",
               wb_valid, ldst_stall, dut.state_q);
    end
    tick();
    dmem_if.rvalid = 1'b0;
  endtask

  task automatic test_illegal();
    obs_t o;
    run_op(1'b0, 1'b1, 3'b011, 32'h80, 32'h55, 5'd0, 0, 0, 32'h0, o);
    checks++;
    if (o.exc_count != 1 || o.exc_cause !== EXC_ILLEGAL_WIDTH || o.req_cycles != 0) begin
      errors++;
      $display("FAIL st_f3_011 got n=%0d cause=%b req=%0d want 1 10 0", o.exc_count, o.exc_cause, o.req_cycles);
    end
    run_op(1'b1, 1'b0, 3'b111, 32'h83, 32'h0, 5'd1, 0, 0, 32'h0, o);
    checks++;
    if (o.exc_count != 1 || o.exc_cause !== EXC_ILLEGAL_WIDTH || o.wb_count != 0) begin
      errors++;
      $display("FAIL ld_illegal_prio got n=%0d cause=%b wb=%0d want 1 10 0", o.exc_count, o.exc_cause, o.wb_count);
    end
  endtask

  task automatic test_corner_ops();
    obs_t o;
    run_op(1'b1, 1'b1, F3_W, 32'h404, 32'hFFFF_FFFF, 5'd12, 0, 1, 32'h1357_9BDF, o);
    checks++;
    if (o.we !== 1'b0 || o.wb_count != 1 || o.wb_data !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL ld_st_both got we=%b wb=%0d data=%h want 0 1 13579bdf", o.we, o.wb_count, o.wb_data);
    end
    run_op(1'b1, 1'b0, F3_HU, 32'h12, 32'h0, 5'd0, 1, 0, 32'h8001_7FFF, o);
    checks++;
    if (o.req_cycles != 2 || o.wb_count != 1 || o.wb_rd !== 5'd0 || o.wb_data !== 32'h0000_8001) begin
      errors++;
      $display("FAIL ld_rd0 got req=%0d wb=%0d rd=%0d data=%h want 2 1 0 00008001",
               o.req_cycles, o.wb_count, o.wb_rd, o.wb_data);
    end
  endtask

  task automatic test_stale_rsp();
    int bad;
    bad = 0;
    dmem_if.gnt = 1'b1; dmem_if.rvalid = 1'b1;
    repeat (3) begin
      #1;
      if (wb_valid || ldst_stall || dmem_if.req) bad++;
      tick();
    end
    dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stale_rsp got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    bit ld, st;
    int sel, gw, rw;
    logic [2:0] f3;
    logic [31:0] addr, wd, rdata;
    logic [4:0] rd;
    logic [2:0] legal_f3 [5];
    legal_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      ld = (sel >= 1 && sel <= 5);
      st = (sel == 1 || sel >= 6);
      f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      addr = $urandom();
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wd = $urandom(); rdata = $urandom(); rd = 5'($urandom_range(0, 31));
      gw = int'($urandom_range(0, 3)); rw = int'($urandom_range(0, 3));
      e = model(ld, st, f3, addr, wd, rd, gw, rw, rdata);
      run_op(ld, st, f3, addr, wd, rd, gw, rw, rdata, o);
      checks++;
      if (o.timeout || o.unstable || o.stall_cycles != e.stall_cycles || o.req_cycles != e.req_cycles ||
          o.hold_cycles != e.hold_cycles) begin
        errors++;
        $display("FAIL rnd%0d_timing got stall=%0d req=%0d hold=%0d to=%b unst=%b want %0d %0d %0d",
                 i, o.stall_cycles, o.req_cycles, o.hold_cycles, o.timeout, o.unstable,
                 e.stall_cycles, e.req_cycles, e.hold_cycles);
      end
      checks++;
      if (o.exc_count != e.exc_count || (e.exc_count == 1 &&
          (o.exc_cycle != e.exc_cycle || o.exc_cause !== e.exc_cause))) begin
        errors++;
        $display("FAIL rnd%0d_exc got n=%0d cyc=%0d cause=%b want %0d %0d %b",
                 i, o.exc_count, o.exc_cycle, o.exc_cause, e.exc_count, e.exc_cycle, e.exc_cause);
      end
      checks++;
      if (o.wb_count != e.wb_count || (e.wb_count == 1 &&
          (o.wb_data !== e.wb_data || o.wb_rd !== e.wb_rd))) begin
        errors++;
        $display("FAIL rnd%0d_wb got n=%0d data=%h rd=%0d want %0d %h %0d",
                 i, o.wb_count, o.wb_data, o.wb_rd, e.wb_count, e.wb_data, e.wb_rd);
      end
      if (e.req_cycles > 0) begin
        checks++;
        if (o.addr !== e.addr || o.we !== e.we || (e.we && (o.be !== e.be || o.wdata !== e.wdata))) begin
          errors++;
          $display("FAIL rnd%0d_bus got addr=%h we=%b be=%b wd=%h want %h %b %b %h",
                   i, o.addr, o.we, o.be, o.wdata, e.addr, e.we, e.be, e.wdata);
        end
      end
    end
  endtask

  initial begin
    dmem_if.gnt = 1'b0;
    dmem_if.rvalid = 1'b0;
    dmem_if.rdata = '0;
    test_reset();
    test_store_word();
    test_load_byte();
    test_misaligned();
    test_store_half_wait();
    test_illegal();
    test_corner_ops();
    test_stale_rsp();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_ctrl.md
LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk in 1 (rising edge); rst_n in 1 (async assert, active-low).
REQ-002 ex_valid in 1: the EX stage holds a memory instruction.
REQ-003 ex_is_load in 1 and ex_is_store in 1: operation type.
REQ-004 ex_funct3 in 3: access width and sign.
REQ-005 ex_addr in 32: effective address.
REQ-006 ex_wdata in 32: store data.
REQ-007 ex_rd in 5: load destination register.
REQ-008 dmem_req out 1: memory request; dmem_gnt in 1: request accepted.
REQ-009 dmem_we out 1; dmem_addr out 32, word-aligned; dmem_be out 4; dmem_wdata out 32, lane-shifted.
REQ-010 dmem_rvalid in 1 and dmem_rdata in 32: load response.
REQ-011 ldst_stall out 1: freeze the pipeline; drives the stall combiner.
REQ-012 wb_valid out 1, wb_rd out 5, wb_data out 32: load writeback.
REQ-013 exc_valid out 1 and exc_cause out 2: 00 load-misaligned, 01 store-misaligned, 10 illegal-width.

Function
REQ-014 SHALL implement a state machine with three states: IDLE, REQ, WAIT_RSP.
REQ-015 IDLE, legal op (ex_valid & (load|store), aligned, supported funct3):
- latch the operation and go to REQ;
- assert ldst_stall combinationally in that same cycle.
REQ-016 REQ:
- dmem_req=1 with registered addr/be/wdata/we;
- all held stable until dmem_gnt;
- on gnt, a store goes to IDLE and a load goes to WAIT_RSP.
REQ-017 WAIT_RSP: dmem_req=0; on dmem_rvalid, assert wb_valid/wb_rd/wb_data combinationally for exactly that cycle, then go to IDLE.
REQ-018 ldst_stall SHALL be 1 in REQ and in WAIT_RSP, except that it is 0 in the completion cycle (store gnt, or load rvalid), so the pipeline advances at that edge.
REQ-019 Minimum latency SHALL be 2 cycles for a store and 3 cycles for a load, given zero-wait gnt/rvalid; wait states extend the latency without limit.
REQ-020 Widths: funct3 000/100 byte, 001/101 half, 010 word; loads 000/001 sign-extend and 100/101 zero-extend.
REQ-021 Store lanes:
- SB replicates byte[7:0] to all lanes, be=0001<<addr[1:0];
- SH replicates half[15:0], be=0011<<(addr[1]*2);
- SW be=1111.
REQ-022 Misalignment is half with addr[0]=1, or word with addr[1:0]!=0.
REQ-023 Misaligned or unsupported-funct3 ops (stores: funct3>=011; loads: 011, 110, 111):
- no memory request and no stall;
- exc_valid registered one-cycle pulse on the next cycle;
- exc_cause per REQ-013, illegal-width taking priority over misaligned.
REQ-024 ex_is_load and ex_is_store both high SHALL be treated as a load.
REQ-025 ex_valid in REQ or WAIT_RSP SHALL be ignored; no new op is accepted until the FSM returns to IDLE.
REQ-026 dmem_rvalid or dmem_gnt in IDLE SHALL be ignored, covering a stale response after reset.
REQ-027 Loads to rd=0 SHALL still access memory and assert wb_valid with wb_rd=0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE and clear all registered outputs to 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, exc_valid, exc_cause, and the latched rd/funct3/offset.
REQ-029 Reset mid-operation SHALL abandon the access; wb_valid=0 and ldst_stall=0 (combinational outputs 0 while in IDLE with ex_valid=0).

Structure
REQ-030 Shared package SHALL hold:
- the lsu_state_t enum (IDLE, REQ, WAIT_RSP);
- funct3 width localparams;
- exc_cause codes.
REQ-031 One combinational sub-module, lsu_load_align, SHALL perform lane select and sign/zero extension from (rdata, offset, funct3).

Verification
REQ-032 SW addr=0x100, data=0xDEADBEEF, gnt on the first REQ cycle -> dmem_addr=0x100, be=1111, we=1; ldst_stall high for 1 cycle; FSM back to IDLE after 2 cycles.
REQ-033 LB addr=0x203, rdata=0x80xxxxxx -> wb_data=0xFFFFFF80. LBU at the same address -> wb_data=0x00000080. wb_valid for exactly 1 cycle.
REQ-034 LH addr=0x201 -> exc_valid pulse with cause=00 the next cycle; dmem_req never asserted; ldst_stall=0.
REQ-035 SH addr=0x42, data=0x1234, gnt delayed 3 cycles -> dmem_wdata=0x12341234, be=1100, held stable; ldst_stall high for 4 cycles.
REQ-036 LW issued, rst_n pulsed low in WAIT_RSP, then rvalid arrives -> no wb_valid; state IDLE; all outputs 0.
REQ-037 Store funct3=011 -> exc_cause=10; no request.
